// File: rtl/mc_core_pkg.sv
// Shared encodings for the multicycle RV32I-subset core: opcodes, FSM states,
// ALU operations and immediate formats, plus the immediate extender.
package mc_core_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BEQ, S_JAL, S_HALT
    } state_e;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_type_e;

    function automatic logic signed [31:0] imm_ext(input logic [31:0] ir, input imm_type_e t);
        case (t)
            IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return {{20{ir[31]}}, ir[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational 32-bit ALU: add/sub/and/or/signed slt with zero, negative,
// carry and overflow flags. SUB and SLT share the subtractor.
module mc_alu
    import mc_core_pkg::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    input  alu_op_e            op,
    output logic signed [31:0] result,
    output logic               zero,
    output logic               negative,
    output logic               carry,
    output logic               overflow
);

    logic              sub_mode;
    logic signed [31:0] b_eff;
    logic [32:0]       sum;
    logic              lt;

    always_comb begin
        sub_mode = (op == ALU_SUB) || (op == ALU_SLT);
        b_eff    = sub_mode ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub_mode};
        overflow = (a[31] == b_eff[31]) && (sum[31] != a[31]);
        carry    = sum[32];
        // Signed less-than: sign of the difference corrected by overflow
        lt       = sum[31] ^ overflow;
        case (op)
            ALU_ADD, ALU_SUB: result = sum[31:0];
            ALU_AND:          result = a & b;
            ALU_OR:           result = a | b;
            ALU_SLT:          result = {31'd0, lt};
            default:          result = sum[31:0];
        endcase
        zero     = (result == 32'sd0);
        negative = result[31];
    end

endmodule

// File: rtl/mc_riscv_core.sv
// Multicycle RV32I-subset core on a single req/ready memory port.
// Define MC_CORE_ILLEGAL_TRAP_EN to halt on illegal instructions (default: execute as NOP).
module mc_riscv_core
    import mc_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd9600,
    parameter int          NUM_REGS = 32,
    parameter int          LED_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      pc_o,
    output logic [31:0]      result_o,
    output logic [LED_W-1:0] led,
    output logic             halted
);

    localparam int RIDX_W = $clog2(NUM_REGS);

    state_e state, state_nxt;
    logic [31:0] pc, old_pc, ir, mdr, result_q;
    logic signed [31:0] a_q, b_q, alu_out;
    logic [31:0] rf [NUM_REGS];

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    function automatic logic reg_bad(input logic [4:0] r);
        return (NUM_REGS == 16) && r[4];
    endfunction

    logic    illegal;
    state_e  exec_state;
    alu_op_e r_op;

    always_comb begin
        illegal    = 1'b0;
        exec_state = S_FETCH;
        r_op       = ALU_ADD;
        case (opcode)
            OP_R: begin
                exec_state = S_EXEC_R;
                case ({f7, f3})
                    {F7_BASE, F3_ADD_SUB}: r_op = ALU_ADD;
                    {F7_SUB,  F3_ADD_SUB}: r_op = ALU_SUB;
                    {F7_BASE, F3_AND}:     r_op = ALU_AND;
                    {F7_BASE, F3_OR}:      r_op = ALU_OR;
                    {F7_BASE, F3_SLT}:     r_op = ALU_SLT;
                    default:               illegal = 1'b1;
                endcase
                if (reg_bad(rd) || reg_bad(rs1) || reg_bad(rs2)) illegal = 1'b1;
            end
            OP_I: begin
                exec_state = S_EXEC_I;
                if (f3 != F3_ADD_SUB || reg_bad(rd) || reg_bad(rs1)) illegal = 1'b1;
            end
            OP_LW: begin
                exec_state = S_MEM_ADR;
                if (f3 != F3_WORD || reg_bad(rd) || reg_bad(rs1)) illegal = 1'b1;
            end
            OP_SW: begin
                exec_state = S_MEM_ADR;
                if (f3 != F3_WORD || reg_bad(rs1) || reg_bad(rs2)) illegal = 1'b1;
            end
            OP_BEQ: begin
                exec_state = S_BEQ;
                if (f3 != F3_BEQ || reg_bad(rs1) || reg_bad(rs2)) illegal = 1'b1;
            end
            OP_JAL: begin
                exec_state = S_JAL;
                if (reg_bad(rd)) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) exec_state = S_FETCH;
    end

    logic [31:0] rs1_val, rs2_val;

    always_comb begin
        rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1[RIDX_W-1:0]];
        rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2[RIDX_W-1:0]];
    end

    logic signed [31:0] alu_a, alu_b, alu_res;
    alu_op_e            alu_op;
    logic               alu_zero, alu_neg, alu_carry, alu_ovf;
    logic               alu_flags_unused;

    always_comb begin
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = ALU_ADD;
        case (state)
            S_EXEC_R:  alu_op = r_op;
            S_EXEC_I:  alu_b  = imm_ext(ir, IMM_I);
            S_MEM_ADR: begin
                if (opcode == OP_SW) alu_b = imm_ext(ir, IMM_S);
                else                 alu_b = imm_ext(ir, IMM_I);
            end
            S_BEQ:     alu_op = ALU_SUB;
            S_JAL: begin
                alu_a = $signed(old_pc);
                alu_b = 32'sd4;
            end
            default: ;
        endcase
    end

    mc_alu u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .op       (alu_op),
        .result   (alu_res),
        .zero     (alu_zero),
        .negative (alu_neg),
        .carry    (alu_carry),
        .overflow (alu_ovf)
    );

    assign alu_flags_unused = alu_neg ^ alu_carry ^ alu_ovf;

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
`ifdef MC_CORE_ILLEGAL_TRAP_EN
            S_DECODE: state_nxt = illegal ? S_HALT : exec_state;
`else
            S_DECODE: state_nxt = exec_state;
`endif
            S_EXEC_R, S_EXEC_I, S_JAL:     state_nxt = S_ALU_WB;
            S_ALU_WB, S_MEM_WB, S_BEQ:     state_nxt = S_FETCH;
            S_MEM_ADR: state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (mem_ready) state_nxt = S_MEM_WB;
            S_MEM_WR:  if (mem_ready) state_nxt = S_FETCH;
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Architectural control state: FSM, PC and visible result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            result_q <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_FETCH:  if (mem_ready) pc <= pc + 32'd4;
`ifdef MC_CORE_ILLEGAL_TRAP_EN
                S_DECODE: if (illegal) pc <= old_pc;
`endif
                S_BEQ:    if (alu_zero) pc <= old_pc + $unsigned(imm_ext(ir, IMM_B));
                S_JAL:    pc <= old_pc + $unsigned(imm_ext(ir, IMM_J));
                S_ALU_WB: result_q <= alu_out;
                S_MEM_WB: result_q <= mdr;
                default: ;
            endcase
        end
    end

    // Datapath holding registers and register file; no reset needed
    always_ff @(posedge clk) begin
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    ir     <= mem_rdata;
                    old_pc <= pc;
                end
            end
            S_DECODE: begin
                a_q <= rs1_val;
                b_q <= rs2_val;
            end
            S_EXEC_R, S_EXEC_I, S_MEM_ADR, S_JAL: alu_out <= alu_res;
            S_MEM_RD: if (mem_ready) mdr <= mem_rdata;
            S_ALU_WB: if (rd != 5'd0) rf[rd[RIDX_W-1:0]] <= alu_out;
            S_MEM_WB: if (rd != 5'd0) rf[rd[RIDX_W-1:0]] <= mdr;
            default: ;
        endcase
    end

    // Request is gated by reset so an in-flight transfer drops immediately
    assign mem_req   = reset && (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR);
    assign mem_we    = (state == S_MEM_WR);
    assign mem_wdata = (state == S_MEM_WR) ? b_q : 32'd0;

    always_comb begin
        mem_addr = 32'd0;
        if (reset) begin
            case (state)
                S_FETCH:            mem_addr = {pc[31:2], 2'b00};
                S_MEM_RD, S_MEM_WR: mem_addr = {alu_out[31:2], 2'b00};
                default: ;
            endcase
        end
    end

    assign pc_o     = pc;
    assign result_o = result_q;
    assign led      = result_q[LED_W-1:0];
    assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_mc_riscv_core.sv
// Directed bench for mc_riscv_core: table of instructions with hand-computed
// results/PCs, a wait-state memory model, and reset/handshake sequences.
module tb_mc_riscv_core;

    localparam logic [31:0] B     = 32'd9600;
    localparam int          MEMW  = 1024;
    localparam int          PBASE = 352;
    localparam logic [6:0]  OPI   = 7'b0010011;
    localparam logic [6:0]  OPLW  = 7'b0000011;
    localparam logic [6:0]  F7B   = 7'b0000000;
    localparam logic [6:0]  F7S   = 7'b0100000;
    localparam logic [31:0] ILLEGAL = 32'hFFFF_FFFF;

    logic        clk, reset, mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o, result_o;
    logic [3:0]  led;

    mc_riscv_core #(.RESET_PC(B), .NUM_REGS(32), .LED_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .pc_o      (pc_o),
        .result_o  (result_o),
        .led       (led),
        .halted    (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] img [MEMW];
    logic [31:0] mem [MEMW];
    logic [9:0]  widx;
    int          wait_cfg, wcnt, wr_count, stab_err, wait_cycles;
    logic        prev_wait, prev_we;
    logic [31:0] prev_addr, first_wr_addr, first_wr_data;

    assign widx      = mem_addr[11:2];
    assign mem_rdata = mem[widx];
    assign mem_ready = mem_req && (wcnt >= wait_cfg);

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MEMW; i++) mem[i] <= img[i];
            wcnt        <= 0;
            wr_count    <= 0;
            stab_err    <= 0;
            wait_cycles <= 0;
            prev_wait   <= 1'b0;
        end else begin
            if (mem_req && !mem_ready) begin
                wcnt        <= wcnt + 1;
                wait_cycles <= wait_cycles + 1;
            end
            if (mem_req && mem_ready) begin
                wcnt <= 0;
                if (mem_we) begin
                    mem[widx] <= mem_wdata;
                    if (wr_count == 0) begin
                        first_wr_addr <= mem_addr;
                        first_wr_data <= mem_wdata;
                    end
                    wr_count <= wr_count + 1;
                end
            end
            if (prev_wait && !(mem_req && mem_addr == prev_addr && mem_we == prev_we))
                stab_err <= stab_err + 1;
            prev_wait <= mem_req && !mem_ready;
            prev_addr <= mem_addr;
            prev_we   <= mem_we;
        end
    end

    typedef struct {
        logic [31:0] instr;
        int          cycles;
        logic [31:0] res;
        logic [31:0] pc;
    } step_t;

    step_t prog [32];
    int    nsteps;
    int    nchecks, nerrors;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] im;
        im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_step(input logic [31:0] instr, input int cyc, input logic [31:0] res,
                            input logic [31:0] pc);
        prog[nsteps] = '{instr, cyc, res, pc};
        img[PBASE + nsteps] = instr;
        nsteps++;
    endtask

    task automatic run_prog(input string tag);
        for (int i = 0; i < nsteps; i++) begin
            if (prog[i].cycles == 0) continue;
            repeat (prog[i].cycles) @(posedge clk);
            @(negedge clk);
`ifdef MC_CORE_ILLEGAL_TRAP_EN
            if (prog[i].instr == ILLEGAL) begin
                chk($sformatf("%s%0d_halted", tag, i), {31'd0, halted}, 32'd1);
                chk($sformatf("%s%0d_pc_frozen", tag, i), pc_o, prog[i].pc - 32'd4);
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk($sformatf("%s%0d_halt_req", tag, i), {31'd0, mem_req}, 32'd0);
                chk($sformatf("%s%0d_halt_pc", tag, i), pc_o, prog[i].pc - 32'd4);
                break;
            end
`endif
            chk($sformatf("%s%0d_result", tag, i), result_o, prog[i].res);
            chk($sformatf("%s%0d_pc", tag, i), pc_o, prog[i].pc);
            chk($sformatf("%s%0d_led", tag, i), {28'd0, led}, {28'd0, prog[i].res[3:0]});
            chk($sformatf("%s%0d_halted", tag, i), {31'd0, halted}, 32'd0);
        end
    endtask

    initial begin
        nchecks  = 0;
        nerrors  = 0;
        nsteps   = 0;
        wait_cfg = 0;
        reset    = 1'b0;
        for (int i = 0; i < MEMW; i++) img[i] = 32'd0;
        img[2] = 32'hDEAD_BEEF;

        add_step(enc_i(5, 0, 3'b000, 1, OPI),        4, 32'd5,        B + 4);
        add_step(enc_i(7, 0, 3'b000, 2, OPI),        4, 32'd7,        B + 8);
        add_step(enc_r(F7B, 2, 1, 3'b000, 3),        4, 32'd12,       B + 12);
        add_step(enc_i(85, 0, 3'b000, 5, OPI),       4, 32'h55,       B + 16);
        add_step(enc_s(0, 3, 0),                     4, 32'h55,       B + 20);
        add_step(enc_i(0, 0, 3'b010, 4, OPLW),       5, 32'd12,       B + 24);
        add_step(enc_b(8, 1, 1),                     3, 32'd12,       B + 32);
        add_step(enc_i(1, 0, 3'b000, 5, OPI),        0, 32'd0,        32'd0);
        add_step(enc_b(8, 2, 1),                     3, 32'd12,       B + 36);
        add_step(enc_r(F7B, 0, 5, 3'b000, 10),       4, 32'h55,       B + 40);
        add_step(enc_i(1, 0, 3'b000, 6, OPI),        4, 32'd1,        B + 44);
        add_step(enc_r(F7S, 6, 0, 3'b000, 7),        4, 32'hFFFF_FFFF, B + 48);
        add_step(enc_r(F7B, 6, 7, 3'b010, 8),        4, 32'd1,        B + 52);
        add_step(enc_r(F7B, 7, 6, 3'b010, 8),        4, 32'd0,        B + 56);
        add_step(enc_r(F7B, 2, 3, 3'b111, 9),        4, 32'd4,        B + 60);
        add_step(enc_r(F7B, 2, 3, 3'b110, 9),        4, 32'd15,       B + 64);
        add_step(enc_i(9, 0, 3'b000, 0, OPI),        4, 32'd9,        B + 68);
        add_step(enc_r(F7B, 0, 0, 3'b000, 11),       4, 32'd0,        B + 72);
        add_step(enc_s(4, 4, 0),                     4, 32'd0,        B + 76);
        add_step(enc_i(6, 0, 3'b010, 12, OPLW),      5, 32'd12,       B + 80);
        add_step(enc_r(F7B, 6, 7, 3'b000, 13),       4, 32'd0,        B + 84);
        add_step(enc_s(10, 0, 0),                    4, 32'd0,        B + 88);
        add_step(ILLEGAL,                            2, 32'd0,        B + 92);
        add_step(enc_i(33, 0, 3'b000, 14, OPI),      4, 32'h21,       B + 96);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc_o, B);
        chk("rst_result", result_o, 32'd0);
        chk("rst_led", {28'd0, led}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b1;

        run_prog("A");
        chk("A_wr_count", 32'(wr_count), 32'd3);
        chk("A_first_wr_addr", first_wr_addr, 32'd0);
        chk("A_first_wr_data", first_wr_data, 32'd12);
        chk("A_mem0", mem[0], 32'd12);
        chk("A_mem1", mem[1], 32'd12);
        chk("A_mem2", mem[2], 32'd0);

        // Three wait states on every fetch of the first three instructions
        wait_cfg = 3;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("W_result_c20", result_o, 32'd7);
        chk("W_pc_c20", pc_o, B + 12);
        @(posedge clk);
        @(negedge clk);
        chk("W_result_c21", result_o, 32'd12);
        chk("W_led_c21", {28'd0, led}, 32'hC);
        chk("W_pc_c21", pc_o, B + 12);
        chk("W_stability", 32'(stab_err), 32'd0);
        chk("W_wait_cycles", 32'(wait_cycles), 32'd9);

        // Reset while the next fetch is stalled
        chk("R_req_before", {31'd0, mem_req}, 32'd1);
        chk("R_addr_before", mem_addr, B + 12);
        reset = 1'b0;
        #1;
        chk("R_req_after", {31'd0, mem_req}, 32'd0);
        chk("R_pc_after", pc_o, B);
        chk("R_addr_after", mem_addr, 32'd0);

        wait_cfg = 0;
        nsteps = 0;
        add_step(enc_j(16, 1),                       4, 32'd9604,     B + 16);
        add_step(enc_i(1, 0, 3'b000, 9, OPI),        0, 32'd0,        32'd0);
        add_step(enc_i(1, 0, 3'b000, 9, OPI),        0, 32'd0,        32'd0);
        add_step(enc_i(1, 0, 3'b000, 9, OPI),        0, 32'd0,        32'd0);
        add_step(enc_r(F7B, 0, 1, 3'b000, 2),        4, 32'd9604,     B + 20);
        add_step(enc_i(9, 0, 3'b000, 0, OPI),        4, 32'd9,        B + 24);
        add_step(enc_r(F7B, 1, 0, 3'b000, 3),        4, 32'd9604,     B + 28);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_prog("J");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
